// File: rtl/rgb_fade_sequencer.sv
// Palette-driven RGB sequencer: fades three PWM duty channels linearly toward
// each palette entry, holds the colour, then advances (optionally looping).
module rgb_fade_sequencer #(
  parameter int unsigned TICK_DIV   = 100,
  parameter int unsigned HOLD_STEPS = 50,
  parameter int unsigned NUM_COLORS = 4
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          loop_en_i,
  input  logic                          wr_en_i,
  input  logic [$clog2(NUM_COLORS)-1:0] wr_addr_i,
  input  logic [20:0]                   wr_data_i,
  output logic [6:0]                    duty_r_o,
  output logic [6:0]                    duty_g_o,
  output logic [6:0]                    duty_b_o,
  output logic [$clog2(NUM_COLORS)-1:0] color_idx_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned DW   = 7;
  localparam int unsigned RGBW = 3 * DW;
  localparam int unsigned DMAX = 100;
  localparam int unsigned AW   = $clog2(NUM_COLORS);
  localparam int unsigned CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW   = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int unsigned R_LSB = 2 * DW;
  localparam int unsigned G_LSB = DW;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FADE = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
    return (v > DW'(DMAX)) ? DW'(DMAX) : v;
  endfunction

  function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt);
    if (cur < tgt) return cur + DW'(1);
    if (cur > tgt) return cur - DW'(1);
    return cur;
  endfunction

  logic [RGBW-1:0] palette_q [NUM_COLORS];

  state_e          state_q,    state_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [RGBW-1:0] duty_q,     duty_d;
  logic [RGBW-1:0] tgt_q,      tgt_d;
  logic [AW-1:0]   idx_q,      idx_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;

  logic            tick;
  logic            latch;
  logic [AW-1:0]   next_idx;

  // Palette storage; fields above full scale saturate, out-of-range addresses drop
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < int'(NUM_COLORS); i++) palette_q[i] <= '0;
    end else if (wr_en_i && (32'(wr_addr_i) < NUM_COLORS)) begin
      palette_q[wr_addr_i] <= {clamp_duty(wr_data_i[R_LSB +: DW]),
                               clamp_duty(wr_data_i[G_LSB +: DW]),
                               clamp_duty(wr_data_i[B_LSB +: DW])};
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      duty_q     <= '0;
      tgt_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      duty_q     <= duty_d;
      tgt_q      <= tgt_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state: tick pacing, per-channel ramp, hold timing and palette advance
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = '0;
    hold_cnt_d = hold_cnt_q;
    duty_d     = duty_q;
    tgt_d      = tgt_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    latch      = 1'b0;
    next_idx   = '0;

    tick = (state_q != S_IDLE) && (tick_cnt_q == CW'(TICK_DIV - 1));
    if (state_q != S_IDLE) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          latch    = 1'b1;
          next_idx = '0;
        end
      end
      S_FADE: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (tick) begin
          duty_d = {step_toward(duty_q[R_LSB +: DW], tgt_q[R_LSB +: DW]),
                    step_toward(duty_q[G_LSB +: DW], tgt_q[G_LSB +: DW]),
                    step_toward(duty_q[B_LSB +: DW], tgt_q[B_LSB +: DW])};
          if (duty_d == tgt_q) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      S_HOLD: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (hold_cnt_q == HW'(HOLD_STEPS - 1)) begin
            if (32'(idx_q) < NUM_COLORS - 1) begin
              latch    = 1'b1;
              next_idx = idx_q + AW'(1);
            end else if (loop_en_i) begin
              latch    = 1'b1;
              next_idx = '0;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering an entry snapshots its target and restarts tick pacing
    if (latch) begin
      state_d    = S_FADE;
      idx_d      = next_idx;
      tgt_d      = palette_q[next_idx];
      tick_cnt_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign duty_r_o    = duty_q[R_LSB +: DW];
  assign duty_g_o    = duty_q[G_LSB +: DW];
  assign duty_b_o    = duty_q[B_LSB +: DW];
  assign color_idx_o = idx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with hand-computed edge-accurate expectations.
module tb_rgb_fade_sequencer;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned HOLD_STEPS = 2;
  localparam int unsigned NUM_COLORS = 4;

  logic        clk       = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start, stop, loop_en, wr_en;
  logic [1:0]  wr_addr;
  logic [20:0] wr_data;
  logic [6:0]  duty_r, duty_g, duty_b;
  logic [1:0]  color_idx;
  logic        busy, done;

  logic        s3_start, s3_wr_en;
  logic [1:0]  s3_wr_addr;
  logic [20:0] s3_wr_data;
  logic [6:0]  s3_duty_r, s3_duty_g, s3_duty_b;
  logic [1:0]  s3_color_idx;
  logic        s3_busy, s3_done;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int t0        = 0;
  int done_seen = 0;
  int d0        = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_seen <= done_seen + 1;

  rgb_fade_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .HOLD_STEPS(HOLD_STEPS),
    .NUM_COLORS(NUM_COLORS)
  ) u_dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .loop_en_i  (loop_en),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .duty_r_o   (duty_r),
    .duty_g_o   (duty_g),
    .duty_b_o   (duty_b),
    .color_idx_o(color_idx),
    .busy_o     (busy),
    .done_o     (done)
  );

  // Three-entry palette so that address 3 is genuinely out of range
  rgb_fade_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .HOLD_STEPS(HOLD_STEPS),
    .NUM_COLORS(3)
  ) u_dut3 (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .start_i    (s3_start),
    .stop_i     (1'b0),
    .loop_en_i  (1'b0),
    .wr_en_i    (s3_wr_en),
    .wr_addr_i  (s3_wr_addr),
    .wr_data_i  (s3_wr_data),
    .duty_r_o   (s3_duty_r),
    .duty_g_o   (s3_duty_g),
    .duty_b_o   (s3_duty_b),
    .color_idx_o(s3_color_idx),
    .busy_o     (s3_busy),
    .done_o     (s3_done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to 1 time unit after edge t0+n, where t0 is the start edge
  task automatic run_to(input int n);
    while (cyc < t0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input int r, input int g, input int b);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {7'(r), 7'(g), 7'(b)};
    step_clk(1);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_clk(1);
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step_clk(1);
    stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start = 0; stop = 0; loop_en = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    s3_start = 0; s3_wr_en = 0; s3_wr_addr = '0; s3_wr_data = '0;

    #12;
    check_eq("rst_duty_r", int'(duty_r), 0);
    check_eq("rst_duty_g", int'(duty_g), 0);
    check_eq("rst_idx", int'(color_idx), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    sys_rst_n = 1'b1;
    step_clk(1);

    // Basic fade up, hold, advance and fade down
    wr(2'd0, 10, 0, 0);
    wr(2'd1, 4, 0, 0);
    pulse_start();
    check_eq("busy_after_start", int'(busy), 1);
    run_to(3);  check_eq("r_before_tick", int'(duty_r), 0);
    run_to(4);  check_eq("r_first_tick", int'(duty_r), 1);
    run_to(40); check_eq("r_peak", int'(duty_r), 10);
    run_to(47); check_eq("idx_in_hold", int'(color_idx), 0);
    run_to(48); check_eq("idx_advance", int'(color_idx), 1);
    run_to(52); check_eq("r_ramp_down", int'(duty_r), 9);

    // Saturating write lands before entry 2 is entered
    wr(2'd2, 120, 0, 0);
    run_to(80);  check_eq("idx_entry2", int'(color_idx), 2);
    check_eq("r_at_entry1", int'(duty_r), 4);
    run_to(100); wr(2'd2, 50, 0, 0);
    run_to(463); check_eq("r_near_top", int'(duty_r), 99);
    run_to(464); check_eq("r_clamped", int'(duty_r), 100);
    check_eq("idx_clamped", int'(color_idx), 2);

    // Asynchronous reset between clock edges
    #3; sys_rst_n = 1'b0;
    #1;
    check_eq("arst_duty_r", int'(duty_r), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_idx", int'(color_idx), 0);
    @(posedge clk); #1; sys_rst_n = 1'b1;
    step_clk(2);
    check_eq("post_rst_busy", int'(busy), 0);

    // Non-looping sequence with equal-colour entry
    wr(2'd0, 5, 5, 5);
    wr(2'd1, 5, 5, 5);
    wr(2'd2, 0, 9, 0);
    wr(2'd3, 3, 3, 3);
    loop_en = 1'b0;
    d0 = done_seen;
    pulse_start();
    run_to(20);  check_eq("seq_g_e0", int'(duty_g), 5);
    run_to(28);  check_eq("seq_idx1", int'(color_idx), 1);
    run_to(39);  check_eq("seq_idx1_hold", int'(color_idx), 1);
    run_to(40);  check_eq("seq_idx2", int'(color_idx), 2);
    run_to(48);  check_eq("seq_r_mid", int'(duty_r), 3);
    check_eq("seq_g_mid", int'(duty_g), 7);
    run_to(99);  check_eq("seq_done_early", int'(done), 0);
    check_eq("seq_busy_early", int'(busy), 1);
    run_to(100); check_eq("seq_done", int'(done), 1);
    check_eq("seq_busy_end", int'(busy), 0);
    check_eq("seq_r_end", int'(duty_r), 3);
    check_eq("seq_g_end", int'(duty_g), 3);
    check_eq("seq_b_end", int'(duty_b), 3);
    check_eq("seq_idx_end", int'(color_idx), 3);
    step_clk(1);
    check_eq("seq_done_pulse", int'(done), 0);
    check_eq("seq_done_count", done_seen - d0, 1);

    // Looping sequence wraps with no done pulse
    loop_en = 1'b1;
    d0 = done_seen;
    pulse_start();
    run_to(16); check_eq("loop_idx1", int'(color_idx), 1);
    run_to(87); check_eq("loop_idx3", int'(color_idx), 3);
    run_to(88); check_eq("loop_wrap", int'(color_idx), 0);
    check_eq("loop_busy", int'(busy), 1);
    check_eq("loop_no_done", done_seen - d0, 0);
    pulse_stop();
    check_eq("loop_stop_busy", int'(busy), 0);
    loop_en = 1'b0;

    // Stop mid-fade, start+stop collision, start while busy
    sys_rst_n = 1'b0; #2; sys_rst_n = 1'b1;
    step_clk(1);
    wr(2'd0, 20, 0, 0);
    pulse_start();
    run_to(24); check_eq("stop_pre_r", int'(duty_r), 6);
    pulse_stop();
    check_eq("stop_busy", int'(busy), 0);
    check_eq("stop_r_frozen", int'(duty_r), 6);
    step_clk(8);
    check_eq("stop_r_later", int'(duty_r), 6);
    start = 1'b1; stop = 1'b1;
    step_clk(1);
    start = 1'b0; stop = 1'b0;
    check_eq("collide_busy", int'(busy), 0);
    step_clk(8);
    check_eq("collide_r", int'(duty_r), 6);
    check_eq("collide_busy_later", int'(busy), 0);
    wr(2'd0, 6, 0, 0);
    wr(2'd1, 30, 0, 0);
    pulse_start();
    run_to(13);
    start = 1'b1;
    step_clk(1);
    start = 1'b0;
    run_to(16);
    check_eq("busy_start_idx", int'(color_idx), 1);
    check_eq("busy_start_r", int'(duty_r), 7);
    pulse_stop();

    // Write to entry 0 coinciding with start latches the old value
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {7'd40, 7'd0, 7'd0};
    start = 1'b1;
    step_clk(1);
    t0 = cyc;
    wr_en = 1'b0; start = 1'b0;
    run_to(4); check_eq("same_cycle_old", int'(duty_r), 6);
    pulse_stop();
    pulse_start();
    run_to(4); check_eq("write_committed", int'(duty_r), 7);
    pulse_stop();

    // Out-of-range address on the three-entry instance
    s3_wr_en = 1'b1; s3_wr_addr = 2'd3; s3_wr_data = {7'd9, 7'd9, 7'd9};
    step_clk(1);
    s3_wr_addr = 2'd0; s3_wr_data = {7'd2, 7'd0, 7'd0};
    step_clk(1);
    s3_wr_en = 1'b0;
    s3_start = 1'b1;
    step_clk(1);
    t0 = cyc;
    s3_start = 1'b0;
    run_to(8);  check_eq("s3_r_peak", int'(s3_duty_r), 2);
    run_to(43); check_eq("s3_busy", int'(s3_busy), 1);
    run_to(44); check_eq("s3_done", int'(s3_done), 1);
    check_eq("s3_idx_end", int'(s3_color_idx), 2);
    check_eq("s3_r_end", int'(s3_duty_r), 0);
    check_eq("s3_g_end", int'(s3_duty_g), 0);
    check_eq("s3_b_end", int'(s3_duty_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
